// File: rtl/gcd_pkg.sv
// Shared types and widths for the GCD job sequencer and its operand FIFO.
package gcd_pkg;

  localparam int unsigned GCD_DATA_W = 32;
  localparam int unsigned GCD_TAG_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    OUT
  } gcd_seq_state_t;

  typedef struct packed {
    logic [GCD_DATA_W-1:0] a;
    logic [GCD_DATA_W-1:0] b;
    logic [GCD_TAG_W-1:0]  tag;
  } gcd_job_t;

endpackage

// File: rtl/gcd_job_fifo.sv
// Operand FIFO for GCD jobs; pointers carry an extra wrap bit to tell full from empty.
module gcd_job_fifo
  import gcd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  logic     pop,
  input  gcd_job_t wr_data,
  output gcd_job_t rd_data,
  output logic     full,
  output logic     empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  gcd_job_t    mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/gcd_job_sequencer.sv
// Queues (a,b,tag) jobs and runs them one at a time on the GCD engine, returning tagged results.
// Build option GCD_ZERO_BYPASS_EN: jobs with a zero operand complete without using the engine.
module gcd_job_sequencer
  import gcd_pkg::*;
#(
  parameter int unsigned DATA_W     = GCD_DATA_W,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TAG_W      = GCD_TAG_W,
  parameter int unsigned START_HOLD = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              eng_start,
  output logic [DATA_W-1:0] eng_a,
  output logic [DATA_W-1:0] eng_b,
  input  logic              eng_done,
  input  logic [DATA_W-1:0] eng_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  localparam int unsigned   HC_W      = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(START_HOLD - 1);

  gcd_seq_state_t   state;
  gcd_seq_state_t   state_nxt;
  logic [HC_W-1:0]  hold_cnt;
  logic [TAG_W-1:0] job_tag;

  gcd_job_t push_job;
  gcd_job_t head;
  logic     fifo_full;
  logic     fifo_empty;
  logic     push;
  logic     pop;

  logic load_job;
  logic capture;
  logic bypass;
  logic out_ack;

  assign push_job = '{a: in_a, b: in_b, tag: in_tag};
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;

  gcd_job_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (push_job),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load_job  = 1'b0;
    capture   = 1'b0;
    bypass    = 1'b0;
    out_ack   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          load_job  = 1'b1;
          state_nxt = START;
`ifdef GCD_ZERO_BYPASS_EN
          if (head.a == '0 || head.b == '0) begin
            bypass    = 1'b1;
            state_nxt = OUT;
          end
`endif
        end
      end
      // eng_done is deliberately not looked at here: it may still be high from the previous job
      START: begin
        if (hold_cnt == HOLD_LAST) state_nxt = WAIT;
      end
      WAIT: begin
        if (eng_done) begin
          capture   = 1'b1;
          state_nxt = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          out_ack   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || state != START || state_nxt != START) hold_cnt <= '0;
    else                                               hold_cnt <= hold_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      eng_a      <= '0;
      eng_b      <= '0;
      job_tag    <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else begin
      if (load_job) begin
        eng_a   <= head.a;
        eng_b   <= head.b;
        job_tag <= head.tag;
      end
      if (capture) begin
        out_result <= eng_result;
        out_tag    <= job_tag;
        out_valid  <= 1'b1;
      end else if (bypass) begin
        out_result <= head.a | head.b;
        out_tag    <= head.tag;
        out_valid  <= 1'b1;
      end else if (out_ack) begin
        out_valid  <= 1'b0;
      end
    end
  end

  assign eng_start = (state == START);
  assign busy      = !fifo_empty || (state != IDLE);

endmodule
